// File: rtl/antirebote_pkg.sv
// Shared defaults and counter-width helpers for the antirebote_n debouncer.
package antirebote_pkg;

  localparam int DEF_DELAY         = 10000;
  localparam int DEF_REPEAT_DELAY  = 5000000;
  localparam int DEF_REPEAT_PERIOD = 1000000;

  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounce channel: 2-FF sync, stable-window filter, edge pulses.
// Auto-repeat is built only when ANTIREBOTE_REPEAT_EN is defined.
module antirebote_canal
  import antirebote_pkg::*;
#(
  parameter int   DELAY         = DEF_DELAY,
  parameter logic INIT          = 1'b0,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic senout,
  output logic sen,
  output logic rise,
  output logic fall,
  output logic rep
);

  localparam int CW = cnt_w(DELAY);
  localparam logic [CW-1:0] W_MAX = CW'(DELAY);

  logic          r_s1;
  logic          r_s2;
  logic          r_kk;
  logic          r_sen;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_count;

  logic w_hit;
  logic w_rise;
  logic w_fall;

  assign w_hit  = (r_s2 == r_kk) && (r_count == W_MAX);
  assign w_rise = w_hit & r_kk & ~r_sen;
  assign w_fall = w_hit & ~r_kk & r_sen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= INIT;
      r_s2    <= INIT;
      r_kk    <= INIT;
      r_sen   <= INIT;
      r_count <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= senout;
      r_s2   <= r_s1;
      r_rise <= w_rise;
      r_fall <= w_fall;
      if (r_s2 != r_kk) begin
        r_kk    <= r_s2;
        r_count <= '0;
      end else if (r_count == W_MAX) begin
        r_sen <= r_kk;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign sen  = r_sen;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef ANTIREBOTE_REPEAT_EN
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] W_RD = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] W_RP = RW'(REPEAT_PERIOD);

  logic [RW-1:0] r_rcnt;
  logic          r_first;
  logic          r_rep;
  logic [RW-1:0] w_rnext;
  logic [RW-1:0] w_rgoal;

  assign w_rnext = r_rcnt + 1'b1;
  assign w_rgoal = r_first ? W_RD : W_RP;

  // first interval after rise is REPEAT_DELAY, later ones REPEAT_PERIOD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcnt  <= '0;
      r_first <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_rep <= 1'b0;
      if (w_rise) begin
        r_rcnt  <= '0;
        r_first <= 1'b1;
      end else if (w_fall || !r_sen) begin
        r_rcnt  <= '0;
        r_first <= 1'b0;
      end else if (w_rnext == w_rgoal) begin
        r_rcnt  <= '0;
        r_first <= 1'b0;
        r_rep   <= 1'b1;
      end else begin
        r_rcnt <= w_rnext;
      end
    end
  end

  assign rep = r_rep;
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/antirebote_n.sv
// N-channel debouncer top: per-channel filters plus the any-event OR.
// Optional auto-repeat: define ANTIREBOTE_REPEAT_EN.
module antirebote_n
  import antirebote_pkg::*;
#(
  parameter int   N             = 4,
  parameter int   DELAY         = DEF_DELAY,
  parameter logic INIT          = 1'b0,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] senout,
  output logic [N-1:0] sen,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rep,
  output logic         any
);

  for (genvar i = 0; i < N; i++) begin : g_canal
    antirebote_canal #(
      .DELAY         (DELAY),
      .INIT          (INIT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .senout (senout[i]),
      .sen    (sen[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .rep    (rep[i])
    );
  end

  assign any = |(rise | fall);

endmodule

// File: tb/tb_antirebote_n.sv
// Directed bench for antirebote_n with a cycle-stamped expectation queue.
module tb_antirebote_n;

`ifdef ANTIREBOTE_REPEAT_EN
  localparam bit REPON = 1'b1;
`else
  localparam bit REPON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] senout = 4'h0;
  logic [3:0] sen;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rep;
  logic       any;

  antirebote_n #(
    .N             (4),
    .DELAY         (4),
    .INIT          (1'b0),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .senout (senout),
    .sen    (sen),
    .rise   (rise),
    .fall   (fall),
    .rep    (rep),
    .any    (any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] p;
    logic       a;
    bit         pc;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   ntot  = 0;
  int   npass = 0;
  int   nfail = 0;

  task automatic chk(string tag, logic [3:0] o,
                     logic [3:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic push(int c, logic [3:0] s,
                      logic [3:0] r, logic [3:0] f,
                      logic a, logic [3:0] p, bit pc,
                      string tag);
    exp_t e;
    e.c = c; e.s = s; e.r = r; e.f = f;
    e.a = a; e.p = p; e.pc = pc; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(int c0, int c1, logic [3:0] s,
                      string tag);
    for (int c = c0; c <= c1; c++)
      push(c, s, 4'h0, 4'h0, 1'b0, 4'h0, !REPON, tag);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c == cyc) begin
        e = q[i];
        chk({e.tag, ".sen"}, sen, e.s);
        chk({e.tag, ".rise"}, rise, e.r);
        chk({e.tag, ".fall"}, fall, e.f);
        chk({e.tag, ".any"}, {3'b0, any}, {3'b0, e.a});
        if (e.pc) chk({e.tag, ".rep"}, rep, e.p);
        q.delete(i);
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".sen"}, sen, 4'h0);
    chk({tag, ".rise"}, rise, 4'h0);
    chk({tag, ".fall"}, fall, 4'h0);
    chk({tag, ".rep"}, rep, 4'h0);
    chk({tag, ".any"}, {3'b0, any}, 4'h0);
  endtask

  int c;
  int d;

  initial begin
    reset  = 1'b0;
    senout = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    cyc   = 0;
    idle(1, 7, 4'h0, "rel");
    push(8, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, !REPON, "rel");
    idle(9, 9, 4'hF, "rel");
    ticks(9);

    c = cyc;
    senout = 4'h0;
    idle(c + 1, c + 7, 4'hF, "alldn");
    push(c + 8, 4'h0, 4'h0, 4'hF, 1'b1, 4'h0, !REPON, "alldn");
    idle(c + 9, c + 9, 4'h0, "alldn");
    ticks(9);

    c = cyc;
    senout = 4'b0001;
    idle(c + 1, c + 7, 4'h0, "step");
    push(c + 8, 4'b0001, 4'b0001, 4'h0, 1'b1, 4'h0, !REPON, "step");
    idle(c + 9, c + 9, 4'b0001, "step");
    ticks(9);

    c = cyc;
    idle(c + 1, c + 19, 4'b0001, "bnc");
    push(c + 20, 4'b0011, 4'b0010, 4'h0, 1'b1, 4'h0, !REPON, "bnc");
    idle(c + 21, c + 21, 4'b0011, "bnc");
    senout[1] = 1'b1; ticks(3);
    senout[1] = 1'b0; ticks(3);
    senout[1] = 1'b1; ticks(3);
    senout[1] = 1'b0; ticks(3);
    senout[1] = 1'b1; ticks(9);

    c = cyc;
    idle(c + 1, c + 15, 4'b0011, "glitch");
    senout[2] = 1'b1; ticks(3);
    senout[2] = 1'b0; ticks(12);

    c = cyc;
    senout = 4'b1010;
    idle(c + 1, c + 7, 4'b0011, "simul");
    push(c + 8, 4'b1010, 4'b1000, 4'b0001, 1'b1, 4'h0, !REPON, "simul");
    idle(c + 9, c + 9, 4'b1010, "simul");
    ticks(9);

    c = cyc;
    senout = 4'b1110;
    idle(c + 1, c + 5, 4'b1010, "midcnt");
    ticks(5);
    reset = 1'b0;
    #1;
    chk_zero("async");
    senout = 4'h0;
    ticks(2);
    chk_zero("hold");
    reset = 1'b1;
    c = cyc;
    idle(c + 1, c + 12, 4'h0, "rel2");
    ticks(12);

`ifdef ANTIREBOTE_REPEAT_EN
    c = cyc;
    senout = 4'b0001;
    idle(c + 1, c + 7, 4'h0, "rpt");
    push(c + 8, 4'b0001, 4'b0001, 4'h0, 1'b1, 4'h0, 1'b1, "rpt");
    for (int k = c + 9; k <= c + 30; k++)
      push(k, 4'b0001, 4'h0, 4'h0, 1'b0,
           (k == c + 18 || k == c + 23 || k == c + 28)
             ? 4'b0001 : 4'h0, 1'b1, "rpt");
    ticks(30);
    d = cyc;
    senout = 4'h0;
    for (int k = d + 1; k <= d + 7; k++)
      push(k, 4'b0001, 4'h0, 4'h0, 1'b0,
           (k == d + 3) ? 4'b0001 : 4'h0, 1'b1, "rptrel");
    push(d + 8, 4'h0, 4'h0, 4'b0001, 1'b1, 4'h0, 1'b1, "rptrel");
    for (int k = d + 9; k <= d + 15; k++)
      push(k, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, "rptrel");
    ticks(15);
`endif

    chk("qleft", q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
